// File: rtl/alu_rr_arbiter_pkg.sv
// Shared opcode, FSM state and payload definitions for the round-robin ALU arbiter.
package alu_ctrl_defs;

  localparam int unsigned DW   = 4;
  localparam int unsigned SELW = 2;

  localparam logic [SELW-1:0] OP_AND = 2'b00;
  localparam logic [SELW-1:0] OP_OR  = 2'b01;
  localparam logic [SELW-1:0] OP_XOR = 2'b10;
  localparam logic [SELW-1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  typedef struct packed {
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [SELW-1:0] sel;
  } alu_req_t;

  typedef struct packed {
    logic [DW-1:0] out;
    logic          carry;
    logic          zero;
  } alu_rsp_t;

endpackage

// File: rtl/alu.sv
// Existing 4-bit ALU: AND/OR/XOR/ADD with carry and zero flags.
module alu
  import alu_ctrl_defs::*;
(
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [SELW-1:0] sel,
  output logic [DW-1:0]   out,
  output logic            carry_out,
  output logic            zero_flag
);

  logic [DW:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    out       = '0;
    carry_out = 1'b0;
    case (sel)
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_XOR:  out = a ^ b;
      default: {carry_out, out} = sum;
    endcase
    zero_flag = (out == '0);
  end

endmodule

// File: rtl/alu_rr_arbiter_pick.sv
// Round-robin winner search starting at ptr, wrapping past NREQ-1 back to 0.
module alu_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant_c,
  output logic [IDW-1:0]  grant_id_c,
  output logic            any_valid_c
);

  logic [IDW-1:0] idx;

  always_comb begin
    grant_c     = '0;
    grant_id_c  = '0;
    any_valid_c = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(ptr) + k) % NREQ);
      if (!any_valid_c && req_valid[idx]) begin
        grant_c[idx] = 1'b1;
        grant_id_c   = idx;
        any_valid_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one ALU among NREQ valid/ready requesters; one op in flight, result
// returned on a registered, ID-tagged valid/ready response port.
module alu_rr_arbiter
  import alu_ctrl_defs::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [DW*NREQ-1:0]   req_a,
  input  logic [DW*NREQ-1:0]   req_b,
  input  logic [SELW*NREQ-1:0] req_sel,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [DW-1:0]        rsp_out,
  output logic                 rsp_carry,
  output logic                 rsp_zero,
  output logic                 busy
);

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic [IDW-1:0] op_id, op_id_nxt;
  alu_req_t       op, op_nxt;
  logic           rsp_valid_nxt;
  logic [IDW-1:0] rsp_id_nxt;
  alu_rsp_t       rsp_q, rsp_nxt;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            any_valid;
  logic [IDW-1:0]  ptr_wrap;
  alu_req_t        pick_op;

  logic [DW-1:0] alu_out;
  logic          alu_carry;
  logic          alu_zero;

  alu_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid  (req_valid),
    .ptr        (ptr),
    .grant_c    (grant),
    .grant_id_c (grant_id),
    .any_valid_c(any_valid)
  );

  alu u_alu (
    .a        (op.a),
    .b        (op.b),
    .sel      (op.sel),
    .out      (alu_out),
    .carry_out(alu_carry),
    .zero_flag(alu_zero)
  );

  // Operand mux for the granted requester.
  always_comb begin
    pick_op = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        pick_op.a   = req_a[DW*i +: DW];
        pick_op.b   = req_b[DW*i +: DW];
        pick_op.sel = req_sel[SELW*i +: SELW];
      end
    end
  end

  assign ptr_wrap = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    op_nxt        = op;
    op_id_nxt     = op_id;
    rsp_valid_nxt = rsp_valid;
    rsp_id_nxt    = rsp_id;
    rsp_nxt       = rsp_q;
    req_ready     = '0;
    unique case (state)
      S_IDLE: begin
        if (any_valid) begin
          req_ready = grant;
          op_nxt    = pick_op;
          op_id_nxt = grant_id;
          ptr_nxt   = ptr_wrap;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_nxt       = '{out: alu_out, carry: alu_carry, zero: alu_zero};
        rsp_id_nxt    = op_id;
        rsp_valid_nxt = 1'b1;
        state_nxt     = S_RESP;
      end
      S_RESP: begin
        // Data fields deliberately keep their value after the handshake.
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      op        <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_q     <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      op        <= op_nxt;
      op_id     <= op_id_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_id    <= rsp_id_nxt;
      rsp_q     <= rsp_nxt;
    end
  end

  assign rsp_out   = rsp_q.out;
  assign rsp_carry = rsp_q.carry;
  assign rsp_zero  = rsp_q.zero;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: cycle model predicts grants/handshakes,
// expected results are queued at accept and compared while the response is held.
module tb_alu_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_out;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        busy;

  alu_rr_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_sel  (req_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_out  (rsp_out),
    .rsp_carry(rsp_carry),
    .rsp_zero (rsp_zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [3:0] out;
    logic       c;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   errors = 0;
  int   checks = 0;

  int         mstate;
  int         mptr;
  int         w;
  int         j;
  int         gid;
  logic [3:0] exp_rr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t alu_model(input int id, input logic [3:0] a, input logic [3:0] b,
                                     input logic [1:0] sel);
    exp_t       e;
    logic [4:0] s;
    s    = {1'b0, a} + {1'b0, b};
    e.id = id;
    e.c  = 1'b0;
    case (sel)
      2'b00:   e.out = a & b;
      2'b01:   e.out = a | b;
      2'b10:   e.out = a ^ b;
      default: begin e.out = s[3:0]; e.c = s[4]; end
    endcase
    e.z = (e.out == 4'h0);
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] sel);
    req_valid[i]       = v;
    req_a[4*i +: 4]    = a;
    req_b[4*i +: 4]    = b;
    req_sel[2*i +: 2]  = sel;
  endtask

  task automatic run_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    set_req(i, 1'b1, a, b, sel);
    tick(1);
    set_req(i, 1'b0, a, b, sel);
    tick(3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_out", 32'(rsp_out), 0);
    check("rst_rsp_carry", 32'(rsp_carry), 0);
    check("rst_rsp_zero", 32'(rsp_zero), 0);
    tick(2);
    rst_n = 1'b1;
  endtask

  // Cycle model: inputs change only just after posedge, so the negedge view
  // decides what the next posedge does.
  always @(negedge clk) begin
    if (!rst_n) begin
      mstate = 0;
      mptr   = 0;
      sb.delete();
    end else begin
      case (mstate)
        0: begin
          exp_rr = '0;
          w      = -1;
          for (int k = 0; k < 4; k++) begin
            j = (mptr + k) % 4;
            if (w < 0 && req_valid[j]) w = j;
          end
          if (w >= 0) exp_rr[w] = 1'b1;
          check("req_ready_idle", 32'(req_ready), 32'(exp_rr));
          check("busy_idle", 32'(busy), 0);
          check("rsp_valid_idle", 32'(rsp_valid), 0);
          if (w >= 0) begin
            sb.push_back(alu_model(w, req_a[4*w +: 4], req_b[4*w +: 4], req_sel[2*w +: 2]));
            gid = -1;
            for (int k = 0; k < 4; k++) if (req_ready[k]) gid = k;
            glog.push_back(gid);
            mptr   = (w + 1) % 4;
            mstate = 1;
          end
        end
        1: begin
          check("req_ready_exec", 32'(req_ready), 0);
          check("busy_exec", 32'(busy), 1);
          check("rsp_valid_exec", 32'(rsp_valid), 0);
          mstate = 2;
        end
        default: begin
          check("req_ready_resp", 32'(req_ready), 0);
          check("busy_resp", 32'(busy), 1);
          check("rsp_valid_resp", 32'(rsp_valid), 1);
          if (sb.size() == 0) begin
            check("rsp_unexpected", 1, 0);
          end else begin
            check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
            check("rsp_out", 32'(rsp_out), 32'(sb[0].out));
            check("rsp_carry", 32'(rsp_carry), 32'(sb[0].c));
            check("rsp_zero", 32'(rsp_zero), 32'(sb[0].z));
          end
          if (rsp_ready) begin
            if (sb.size() > 0) void'(sb.pop_front());
            mstate = 0;
          end
        end
      endcase
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    rsp_ready = 1'b1;
    do_reset();
    check("rst_req_ready", 32'(req_ready), 0);
    tick(1);

    // Single requester 2, ADD 5+3.
    run_op(2, 4'b0101, 4'b0011, 2'b11);

    // Carry and zero on requester 0.
    run_op(0, 4'b1111, 4'b0001, 2'b11);
    run_op(0, 4'b1010, 4'b0101, 2'b00);

    // Reset again so the pointer restarts at 0.
    do_reset();
    tick(1);

    // All four valid continuously.
    glog.delete();
    set_req(0, 1'b1, 4'h1, 4'h2, 2'b11);
    set_req(1, 1'b1, 4'b1010, 4'b0101, 2'b10);
    set_req(2, 1'b1, 4'h7, 4'h3, 2'b00);
    set_req(3, 1'b1, 4'b1010, 4'b0000, 2'b01);
    tick(13);
    req_valid = '0;
    tick(3);
    check("order_n", glog.size(), 5);
    if (glog.size() == 5) begin
      check("order0", glog[0], 0);
      check("order1", glog[1], 1);
      check("order2", glog[2], 2);
      check("order3", glog[3], 3);
      check("order4", glog[4], 0);
    end

    // Backpressure with other requesters waiting.
    rsp_ready = 1'b0;
    set_req(2, 1'b1, 4'h9, 4'h8, 2'b11);
    tick(1);
    set_req(2, 1'b0, 4'h9, 4'h8, 2'b11);
    set_req(0, 1'b1, 4'h2, 4'h2, 2'b10);
    set_req(3, 1'b1, 4'h6, 4'hC, 2'b01);
    tick(6);
    rsp_ready = 1'b1;
    glog.delete();
    tick(2);
    set_req(3, 1'b0, 4'h6, 4'hC, 2'b01);
    tick(3);
    set_req(0, 1'b0, 4'h2, 4'h2, 2'b10);
    tick(3);
    check("bp_order_n", glog.size(), 2);
    if (glog.size() == 2) begin
      check("bp_order0", glog[0], 3);
      check("bp_order1", glog[1], 0);
    end

    // Reset while an op is in EXEC.
    set_req(0, 1'b1, 4'h4, 4'h4, 2'b11);
    set_req(1, 1'b1, 4'h5, 4'h5, 2'b11);
    set_req(2, 1'b1, 4'h6, 4'h6, 2'b11);
    set_req(3, 1'b1, 4'h7, 4'h7, 2'b11);
    tick(1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rsp_valid", 32'(rsp_valid), 0);
    check("async_busy", 32'(busy), 0);
    tick(1);
    rst_n = 1'b1;
    glog.delete();
    tick(1);
    req_valid = '0;
    tick(3);
    check("post_rst_n", glog.size(), 1);
    if (glog.size() == 1) check("post_rst_first", glog[0], 0);

    // Requester 1 withdraws before it can be granted.
    glog.delete();
    set_req(0, 1'b1, 4'h3, 4'h3, 2'b11);
    tick(1);
    set_req(0, 1'b0, 4'h3, 4'h3, 2'b11);
    set_req(1, 1'b1, 4'hF, 4'hF, 2'b11);
    set_req(3, 1'b1, 4'hC, 4'h4, 2'b11);
    tick(1);
    set_req(1, 1'b0, 4'hF, 4'hF, 2'b11);
    tick(2);
    set_req(3, 1'b0, 4'hC, 4'h4, 2'b11);
    tick(3);
    check("drop_order_n", glog.size(), 2);
    if (glog.size() == 2) begin
      check("drop_order0", glog[0], 0);
      check("drop_order1", glog[1], 3);
    end

    check("sb_empty", sb.size(), 0);
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
